// File: rtl/xadc_mavg_filter.sv
// Moving average of the last 2^LOG2_TAPS samples of one XADC DRP channel; result 3 cycles after accept.
// in_ready drops while a sample is in flight; a matching strobe then is dropped and sets sticky overrun. Optional PRIME fill: XADC_MAVG_PRIME_EN.
module xadc_mavg_filter #(
   parameter int         LOG2_TAPS = 4,
   parameter logic [6:0] CHANNEL   = 7'h1E
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [6:0]  in_addr,
   input  logic [15:0] in_data,
   output logic        in_ready,
   output logic        out_valid,
   output logic [11:0] out_data,
   output logic [7:0]  dac_code,
   output logic        settled,
   output logic        overrun
);
   localparam int                 TAPS      = 1 << LOG2_TAPS;
   localparam int                 SW        = 12 + LOG2_TAPS;
   localparam logic [LOG2_TAPS:0] FILL_FULL = TAPS[LOG2_TAPS:0];
   localparam logic [LOG2_TAPS-1:0] PTR_ONE = 1;
`ifdef XADC_MAVG_PRIME_EN
   localparam logic [LOG2_TAPS-1:0] PTR_LAST = '1;
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_READ   = 2'd1,
      S_UPDATE = 2'd2
`ifdef XADC_MAVG_PRIME_EN
      , S_PRIME = 2'd3
`endif
   } state_t;

   state_t               state_q, state_d;
   logic [SW-1:0]        sum_q, sum_d;
   logic [LOG2_TAPS-1:0] ptr_q, ptr_d;
   logic [LOG2_TAPS:0]   fill_q, fill_d;
   logic [11:0]          x_q, x_d;
   logic [11:0]          old_q, old_d;
   logic                 in_ready_q, in_ready_d;
   logic                 out_valid_q, out_valid_d;
   logic [11:0]          out_data_q, out_data_d;
   logic [7:0]           dac_q, dac_d;
   logic                 overrun_q, overrun_d;
   logic                 mem_we;
   logic [11:0]          mem_q [TAPS];
   logic                 match, accept;
   logic                 unused_bits;

   assign unused_bits = ^in_data[3:0];
   assign match  = in_valid && (in_addr == CHANNEL);
   assign accept = match && in_ready_q;

   always_comb begin
      state_d     = state_q;
      sum_d       = sum_q;
      ptr_d       = ptr_q;
      fill_d      = fill_q;
      x_d         = x_q;
      old_d       = old_q;
      in_ready_d  = in_ready_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      dac_d       = dac_q;
      overrun_d   = overrun_q | (match && !in_ready_q);
      mem_we      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               x_d        = in_data[15:4];
               in_ready_d = 1'b0;
`ifdef XADC_MAVG_PRIME_EN
               state_d    = (fill_q == '0) ? S_PRIME : S_READ;
`else
               state_d    = S_READ;
`endif
            end
         end
         S_READ: begin
            // Until the window is full the slot holds stale RAM, so it contributes nothing.
            old_d   = (fill_q < FILL_FULL) ? 12'd0 : mem_q[ptr_q];
            state_d = S_UPDATE;
         end
         S_UPDATE: begin
            sum_d       = sum_q + {{LOG2_TAPS{1'b0}}, x_q} - {{LOG2_TAPS{1'b0}}, old_q};
            mem_we      = 1'b1;
            ptr_d       = ptr_q + PTR_ONE;
            if (fill_q < FILL_FULL) fill_d = fill_q + 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = sum_d[LOG2_TAPS +: 12];
            dac_d       = sum_d[LOG2_TAPS+4 +: 8];
            in_ready_d  = 1'b1;
            state_d     = S_IDLE;
         end
`ifdef XADC_MAVG_PRIME_EN
         S_PRIME: begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + PTR_ONE;
            if (ptr_q == PTR_LAST) begin
               sum_d       = {x_q, {LOG2_TAPS{1'b0}}};
               fill_d      = FILL_FULL;
               out_valid_d = 1'b1;
               out_data_d  = x_q;
               dac_d       = x_q[11:4];
               in_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sum_q       <= '0;
         ptr_q       <= '0;
         fill_q      <= '0;
         x_q         <= '0;
         old_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         dac_q       <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         ptr_q       <= ptr_d;
         fill_q      <= fill_d;
         x_q         <= x_d;
         old_q       <= old_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         dac_q       <= dac_d;
         overrun_q   <= overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we && !rst) mem_q[ptr_q] <= x_q;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign dac_code  = dac_q;
   assign settled   = (fill_q == FILL_FULL);
   assign overrun   = overrun_q;
endmodule

// File: tb/tb_xadc_mavg_filter.sv
// Directed bench for xadc_mavg_filter with LOG2_TAPS=2; PRIME expectations when XADC_MAVG_PRIME_EN is defined.
module tb_xadc_mavg_filter;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [6:0]  in_addr;
   logic [15:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [11:0] out_data;
   logic [7:0]  dac_code;
   logic        settled;
   logic        overrun;
   int          checks = 0;
   int          errors = 0;
   int          nvld;

   always #5 clk = ~clk;

   xadc_mavg_filter #(.LOG2_TAPS(2), .CHANNEL(7'h1E)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .dac_code(dac_code),
      .settled(settled), .overrun(overrun)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; drives a strobe for one cycle and returns at the next negedge.
   task automatic send(input logic [6:0] a, input logic [15:0] d);
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'h0;
   endtask

   task automatic sample(input string tag, input logic [15:0] d, input logic [11:0] exp,
                         input logic exp_settled);
      send(7'h1E, d);
      chk({tag, "_rdy1"}, in_ready, 1'b0);
      @(negedge clk);
      chk({tag, "_rdy2"}, in_ready, 1'b0);
      chk({tag, "_early"}, out_valid, 1'b0);
      @(negedge clk);
      chk({tag, "_vld"}, out_valid, 1'b1);
      chk({tag, "_dat"}, out_data, exp);
      chk({tag, "_set"}, settled, exp_settled);
      chk({tag, "_rdy3"}, in_ready, 1'b1);
   endtask

   task automatic count_vld(input int n);
      nvld = 0;
      for (int i = 0; i < n; i++) begin
         if (out_valid) nvld++;
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_addr = 7'h1E; in_data = 16'h0;
      repeat (2) @(negedge clk);
      chk("rst_rdy", in_ready, 1'b1);
      chk("rst_vld", out_valid, 1'b0);
      chk("rst_dat", out_data, 12'h000);
      chk("rst_dac", dac_code, 8'h00);
      chk("rst_set", settled, 1'b0);
      chk("rst_ovr", overrun, 1'b0);
      rst = 1'b0;
      @(negedge clk);

`ifdef XADC_MAVG_PRIME_EN
      send(7'h1E, 16'h8000);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("prime_rdy%0d", i), in_ready, 1'b0);
         chk($sformatf("prime_vld%0d", i), out_valid, 1'b0);
         @(negedge clk);
      end
      chk("prime_vld", out_valid, 1'b1);
      chk("prime_dat", out_data, 12'h800);
      chk("prime_set", settled, 1'b1);
      chk("prime_dac", dac_code, 8'h80);
      sample("post", 16'h0000, 12'h600, 1'b1);
      chk("post_dac", dac_code, 8'h60);
`else
      sample("ramp0", 16'hFFF0, 12'h3FF, 1'b0);
      sample("ramp1", 16'hFFF0, 12'h7FF, 1'b0);
      sample("ramp2", 16'hFFF0, 12'hBFF, 1'b0);
      sample("ramp3", 16'hFFF0, 12'hFFF, 1'b1);
      chk("ramp_dac", dac_code, 8'hFF);
      sample("wrap0", 16'h0000, 12'hBFF, 1'b1);
      chk("wrap0_dac", dac_code, 8'hBF);
      sample("wrap1", 16'h0000, 12'h7FF, 1'b1);
      sample("wrap2", 16'h0000, 12'h3FF, 1'b1);
      sample("wrap3", 16'h0000, 12'h000, 1'b1);
      chk("wrap_dac", dac_code, 8'h00);
`endif

      send(7'h17, 16'hFFF0);
      count_vld(5);
      chk("addr_novld", nvld, 0);
      chk("addr_ovr", overrun, 1'b0);
      chk("addr_rdy", in_ready, 1'b1);

`ifndef XADC_MAVG_PRIME_EN
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      send(7'h1E, 16'h4000);
      send(7'h1E, 16'hFFF0);
      chk("ovr_set", overrun, 1'b1);
      @(negedge clk);
      chk("ovr_vld", out_valid, 1'b1);
      chk("ovr_dat", out_data, 12'h100);
      chk("ovr_set0", settled, 1'b0);
      @(negedge clk);
      count_vld(4);
      chk("ovr_novld", nvld, 0);
      chk("ovr_hold", out_data, 12'h100);
      chk("ovr_sticky", overrun, 1'b1);

      send(7'h1E, 16'hFFF0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      count_vld(4);
      chk("mid_novld", nvld, 0);
      chk("mid_ovr", overrun, 1'b0);
      chk("mid_dat", out_data, 12'h000);
      sample("mid", 16'h8000, 12'h200, 1'b0);
      chk("mid_dac", dac_code, 8'h20);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
